// File: rtl/l2_bank_arbiter_pkg.sv
// Shared types and default sizes for the L2 bank arbiter slice.
package l2_bank_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } l2_bank_state_e;

  localparam int unsigned L2_ADDR_WIDTH = 13;
  localparam int unsigned L2_DATA_WIDTH = 32;
  localparam int unsigned L2_BE_WIDTH   = L2_DATA_WIDTH / 8;
  localparam int unsigned L2_BANK_WORDS = 1 << L2_ADDR_WIDTH;
  localparam logic [31:0] L2_BASE_ADDR  = 32'h1C00_0000;

  // One TCDM request as seen after the master mux.
  typedef struct packed {
    logic [31:0]              add;
    logic                     wen;
    logic [L2_BE_WIDTH-1:0]   be;
    logic [L2_DATA_WIDTH-1:0] wdata;
  } tcdm_req_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/l2_bank_arbiter_if.sv
// TCDM request/response bundle for all masters sharing one L2 bank.
//
// Handshake: a master raises req[k] with add/wen/be/wdata and holds all of
// them stable until gnt[k] is seen high in the same cycle; the transfer
// happens on that edge. Exactly one cycle later r_valid[k] pulses (reads and
// writes alike) and r_rdata[k] is meaningful only while r_valid[k] is high.
interface l2_bank_arbiter_if #(
  parameter int unsigned NB_MASTERS = 3,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic [NB_MASTERS-1:0]                 req;
  logic [NB_MASTERS-1:0][31:0]           add;
  logic [NB_MASTERS-1:0]                 wen;
  logic [NB_MASTERS-1:0][BE_WIDTH-1:0]   be;
  logic [NB_MASTERS-1:0][DATA_WIDTH-1:0] wdata;
  logic [NB_MASTERS-1:0]                 gnt;
  logic [NB_MASTERS-1:0]                 r_valid;
  logic [NB_MASTERS-1:0][DATA_WIDTH-1:0] r_rdata;

  modport master (
    output req, add, wen, be, wdata,
    input  gnt, r_valid, r_rdata
  );

  modport slave (
    input  req, add, wen, be, wdata,
    output gnt, r_valid, r_rdata
  );

endinterface

// File: rtl/l2_bank_arbiter_rr_arbiter_tree.sv
// Round-robin priority select: grants the first requester at or after ptr,
// searching cyclically. Outputs the one-hot grant and its index.
module rr_arbiter_tree #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin : select
    logic [IDX_W-1:0] k;
    k   = '0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      k = IDX_W'((32'(ptr) + i) % N);
      if (en && !any && req[k]) begin
        any    = 1'b1;
        idx    = k;
        gnt[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_bank_arbiter.sv
// Shares one single-port, 1-cycle-latency L2 SRAM bank among NB_MASTERS TCDM
// requesters, with a hardware zero-fill after reset or on request.
module l2_bank_arbiter
  import l2_bank_pkg::*;
#(
  parameter int unsigned NB_MASTERS    = 3,
  parameter int unsigned ADDR_WIDTH    = L2_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH    = L2_DATA_WIDTH,
  parameter logic [31:0] BASE_ADDR     = L2_BASE_ADDR,
  parameter bit          CLEAR_ON_INIT = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_req_i,
  output logic                    clear_busy_o,
  l2_bank_arbiter_if.slave        bus,
  output logic                    mem_csn_o,
  output logic                    mem_wen_o,
  output logic [DATA_WIDTH/8-1:0] mem_ben_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output l2_bank_state_e          dbg_state
);

  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;
  localparam int unsigned IDX_W      = idx_width(NB_MASTERS);
  localparam int unsigned BANK_WORDS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(BANK_WORDS - 1);
  localparam l2_bank_state_e RESET_STATE = CLEAR_ON_INIT ? CLEAR : SERVE;

  l2_bank_state_e          state, state_next;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [IDX_W-1:0]        rr_ptr;
  logic                    resp_valid;
  logic [IDX_W-1:0]        resp_idx;
  logic [NB_MASTERS-1:0]   gnt;
  logic [IDX_W-1:0]        gnt_idx;
  logic                    any_gnt;
  tcdm_req_t               sel_req;
  logic [NB_MASTERS-1:0]   r_valid;

  rr_arbiter_tree #(
    .N     (NB_MASTERS),
    .IDX_W (IDX_W)
  ) u_arb (
    .en  (state == SERVE),
    .req (bus.req),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (any_gnt)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= RESET_STATE;
    else         state <= state_next;
  end

  // Next-state logic. A clear request lets the current grant complete first.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_cnt == CLR_LAST) state_next = SERVE;
      SERVE:   if (clear_req_i)         state_next = CLEAR;
      default: state_next = RESET_STATE;
    endcase
  end

  // Clear counter, round-robin pointer and response tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clr_cnt    <= '0;
      rr_ptr     <= '0;
      resp_valid <= 1'b0;
      resp_idx   <= '0;
    end else begin
      if (state == CLEAR) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
      if (any_gnt) begin
        rr_ptr <= (gnt_idx == IDX_W'(NB_MASTERS - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
      resp_valid <= any_gnt;
      if (any_gnt) resp_idx <= gnt_idx;
    end
  end

  // Mux the granted master's request fields.
  always_comb begin
    sel_req = '0;
    for (int unsigned k = 0; k < NB_MASTERS; k++) begin
      if (gnt[k]) begin
        sel_req.add   = bus.add[k];
        sel_req.wen   = bus.wen[k];
        sel_req.be    = L2_BE_WIDTH'(bus.be[k]);
        sel_req.wdata = L2_DATA_WIDTH'(bus.wdata[k]);
      end
    end
  end

  // Output logic: bank drive comes from the clear counter or the granted master.
  always_comb begin
    mem_csn_o    = 1'b1;
    mem_wen_o    = 1'b0;
    mem_ben_o    = '0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    clear_busy_o = (state == CLEAR);
    if (state == CLEAR) begin
      mem_csn_o  = 1'b0;
      mem_addr_o = clr_cnt;
    end else if (any_gnt) begin
      mem_csn_o   = 1'b0;
      mem_wen_o   = sel_req.wen;
      mem_ben_o   = ~BE_WIDTH'(sel_req.be);
      // Upper offset bits drop out, so out-of-range addresses alias.
      mem_addr_o  = ADDR_WIDTH'((sel_req.add - BASE_ADDR) >> 2);
      mem_wdata_o = DATA_WIDTH'(sel_req.wdata);
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NB_MASTERS; k++) begin
      r_valid[k]       = resp_valid && (resp_idx == IDX_W'(k));
      bus.r_rdata[k]   = mem_rdata_i;
    end
  end

  assign bus.gnt     = gnt;
  assign bus.r_valid = r_valid;
  assign dbg_state   = state;

endmodule

// File: tb/tb_l2_bank_arbiter.sv
// Directed bench for l2_bank_arbiter with a 16-word bank and a 1-cycle SRAM model.
module tb_l2_bank_arbiter;
  import l2_bank_pkg::*;

  localparam int unsigned NB = 3;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam logic [31:0] BASE = 32'h1C00_0000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           clear_req = 1'b0;
  logic           clear_busy;
  logic           mem_csn, mem_wen;
  logic [BW-1:0]  mem_ben;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata = '0;
  l2_bank_state_e dbg_state;
  logic [DW-1:0]  mem [16] = '{default: 32'hA5A5_A5A5};
  int             checks = 0;
  int             bad = 0;

  l2_bank_arbiter_if #(.NB_MASTERS(NB), .DATA_WIDTH(DW)) bus ();

  l2_bank_arbiter #(
    .NB_MASTERS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .BASE_ADDR(BASE), .CLEAR_ON_INIT(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_req_i(clear_req), .clear_busy_o(clear_busy),
    .bus(bus),
    .mem_csn_o(mem_csn), .mem_wen_o(mem_wen), .mem_ben_o(mem_ben),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .dbg_state(dbg_state)
  );

  // Clock and SRAM model (active-low byte write enables, 1-cycle read).
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!mem_csn) begin
      if (mem_wen) mem_rdata <= mem[mem_addr];
      else for (int b = 0; b < BW; b++)
        if (!mem_ben[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic drive(input int k, input logic r, input logic [31:0] a, input logic w,
                       input logic [BW-1:0] be, input logic [DW-1:0] d);
    bus.req[k] = r; bus.add[k] = a; bus.wen[k] = w; bus.be[k] = be; bus.wdata[k] = d;
  endtask

  task automatic test_reset();
    int nz;
    rst_n = 1'b0;
    #2;
    checks++; if (clear_busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", clear_busy); end
    checks++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL reset_gnt: got %b want 000", bus.gnt); end
    checks++; if (bus.r_valid !== 3'b000) begin bad++; $display("FAIL reset_rvalid: got %b want 000", bus.r_valid); end
    checks++; if (mem_csn !== 1'b0) begin bad++; $display("FAIL reset_csn: got %b want 0", mem_csn); end
    checks++; if (dbg_state !== CLEAR) begin bad++; $display("FAIL reset_state: got %0d want CLEAR", dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b1, BASE + 32'h3C, 1'b1, 4'hF, '0);
    for (int c = 0; c < 16; c++) begin
      #1;
      checks++;
      if (clear_busy !== 1'b1 || bus.gnt !== 3'b000 || mem_csn !== 1'b0 || mem_wen !== 1'b0 ||
          mem_ben !== 4'h0 || mem_addr !== AW'(c)) begin
        bad++;
        $display("FAIL clear_cycle%0d: got busy=%b gnt=%b csn=%b wen=%b ben=%h addr=%0d want 1 000 0 0 0 %0d",
                 c, clear_busy, bus.gnt, mem_csn, mem_wen, mem_ben, mem_addr, c);
      end
      @(negedge clk);
    end
    #1;
    checks++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL post_clear_busy: got %b want 0", clear_busy); end
    checks++;
    if (bus.gnt !== 3'b001 || mem_addr !== 4'd15 || mem_wen !== 1'b1 || mem_csn !== 1'b0) begin
      bad++; $display("FAIL first_grant: got gnt=%b addr=%0d wen=%b csn=%b want 001 15 1 0", bus.gnt, mem_addr, mem_wen, mem_csn);
    end
    @(negedge clk);
    drive(0, 1'b0, '0, 1'b1, 4'hF, '0);
    checks++; if (bus.r_valid !== 3'b001) begin bad++; $display("FAIL first_rvalid: got %b want 001", bus.r_valid); end
    checks++; if (bus.r_rdata[0] !== 32'h0) begin bad++; $display("FAIL first_rdata: got %h want 00000000", bus.r_rdata[0]); end
    nz = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== 32'h0) nz++;
    checks++; if (nz != 0) begin bad++; $display("FAIL clear_fill: got %0d nonzero words want 0", nz); end
  endtask

  task automatic test_partial_write();
    drive(1, 1'b1, BASE + 32'h8, 1'b0, 4'hF, 32'hFFFF_FFFF);
    #1;
    checks++;
    if (bus.gnt !== 3'b010 || mem_addr !== 4'd2 || mem_ben !== 4'h0 || mem_wen !== 1'b0 || mem_wdata !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL pw_fill: got gnt=%b addr=%0d ben=%h wen=%b wdata=%h want 010 2 0 0 ffffffff",
                      bus.gnt, mem_addr, mem_ben, mem_wen, mem_wdata);
    end
    @(negedge clk);
    checks++; if (bus.r_valid !== 3'b010) begin bad++; $display("FAIL pw_fill_rvalid: got %b want 010", bus.r_valid); end
    drive(1, 1'b1, BASE + 32'h8, 1'b0, 4'b0011, 32'hDEAD_BEEF);
    #1;
    checks++; if (bus.gnt !== 3'b010 || mem_ben !== 4'b1100) begin
      bad++; $display("FAIL pw_write: got gnt=%b ben=%b want 010 1100", bus.gnt, mem_ben);
    end
    @(negedge clk);
    checks++; if (bus.r_valid !== 3'b010) begin bad++; $display("FAIL pw_write_rvalid: got %b want 010", bus.r_valid); end
    drive(1, 1'b1, BASE + 32'h8, 1'b1, 4'hF, '0);
    #1;
    checks++; if (bus.gnt !== 3'b010 || mem_wen !== 1'b1) begin
      bad++; $display("FAIL pw_read: got gnt=%b wen=%b want 010 1", bus.gnt, mem_wen);
    end
    @(negedge clk);
    drive(1, 1'b0, '0, 1'b1, 4'hF, '0);
    checks++; if (bus.r_valid !== 3'b010) begin bad++; $display("FAIL pw_read_rvalid: got %b want 010", bus.r_valid); end
    checks++; if (bus.r_rdata[1] !== 32'hFFFF_BEEF) begin bad++; $display("FAIL pw_rdata: got %h want ffffbeef", bus.r_rdata[1]); end
  endtask

  task automatic test_alias();
    drive(0, 1'b1, BASE + (32'd16 << 2), 1'b0, 4'hF, 32'h1234_5678);
    #1;
    checks++; if (bus.gnt !== 3'b001 || mem_addr !== 4'd0) begin
      bad++; $display("FAIL alias_write: got gnt=%b addr=%0d want 001 0", bus.gnt, mem_addr);
    end
    @(negedge clk);
    drive(0, 1'b1, BASE, 1'b1, 4'hF, '0);
    #1;
    checks++; if (bus.gnt !== 3'b001 || mem_addr !== 4'd0) begin
      bad++; $display("FAIL alias_read: got gnt=%b addr=%0d want 001 0", bus.gnt, mem_addr);
    end
    @(negedge clk);
    drive(0, 1'b0, '0, 1'b1, 4'hF, '0);
    checks++; if (bus.r_valid !== 3'b001 || bus.r_rdata[0] !== 32'h1234_5678) begin
      bad++; $display("FAIL alias_rdata: got v=%b d=%h want 001 12345678", bus.r_valid, bus.r_rdata[0]);
    end
  endtask

  task automatic test_reset_mid_clear();
    int nz;
    drive(2, 1'b1, BASE + 32'hC, 1'b1, 4'hF, '0);
    #1;
    checks++; if (bus.gnt !== 3'b100) begin bad++; $display("FAIL rmc_gnt: got %b want 100", bus.gnt); end
    @(negedge clk);
    drive(2, 1'b0, '0, 1'b1, 4'hF, '0);
    #1;
    checks++; if (bus.r_valid !== 3'b100) begin bad++; $display("FAIL rmc_rvalid: got %b want 100", bus.r_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.r_valid !== 3'b000 || clear_busy !== 1'b1 || mem_csn !== 1'b0 || mem_addr !== 4'd0 || dbg_state !== CLEAR) begin
      bad++; $display("FAIL rmc_async1: got v=%b busy=%b csn=%b addr=%0d want 000 1 0 0", bus.r_valid, clear_busy, mem_csn, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #1;
      checks++; if (mem_addr !== AW'(c) || clear_busy !== 1'b1) begin
        bad++; $display("FAIL rmc_pre%0d: got addr=%0d busy=%b want %0d 1", c, mem_addr, clear_busy, c);
      end
      @(negedge clk);
    end
    #1;
    checks++; if (mem_addr !== 4'd7) begin bad++; $display("FAIL rmc_at7: got %0d want 7", mem_addr); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_addr !== 4'd0 || clear_busy !== 1'b1 || mem_csn !== 1'b0) begin
      bad++; $display("FAIL rmc_async2: got addr=%0d busy=%b csn=%b want 0 1 0", mem_addr, clear_busy, mem_csn);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      checks++; if (mem_addr !== AW'(c) || clear_busy !== 1'b1 || bus.gnt !== 3'b000) begin
        bad++; $display("FAIL rmc_full%0d: got addr=%0d busy=%b gnt=%b want %0d 1 000", c, mem_addr, clear_busy, bus.gnt, c);
      end
      @(negedge clk);
    end
    #1;
    checks++; if (clear_busy !== 1'b0 || dbg_state !== SERVE) begin
      bad++; $display("FAIL rmc_done: got busy=%b state=%0d want 0 SERVE", clear_busy, dbg_state);
    end
    nz = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== 32'h0) nz++;
    checks++; if (nz != 0) begin bad++; $display("FAIL rmc_fill: got %0d nonzero words want 0", nz); end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] exp_d [3];
    exp_d = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    for (int k = 0; k < 3; k++) drive(k, 1'b1, BASE + 32'(4 * (k + 1)), 1'b0, 4'hF, exp_d[k]);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.gnt !== NB'(1 << i) || mem_addr !== AW'(i + 1) || mem_wen !== 1'b0) begin
        bad++; $display("FAIL rr_write%0d: got gnt=%b addr=%0d wen=%b want %b %0d 0", i, bus.gnt, mem_addr, mem_wen, NB'(1 << i), i + 1);
      end
      @(negedge clk);
      checks++; if (bus.r_valid !== NB'(1 << i)) begin
        bad++; $display("FAIL rr_write_rvalid%0d: got %b want %b", i, bus.r_valid, NB'(1 << i));
      end
      drive(i, 1'b0, '0, 1'b1, 4'hF, '0);
    end
    for (int k = 0; k < 3; k++) drive(k, 1'b1, BASE + 32'(4 * (k + 1)), 1'b1, 4'hF, '0);
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (bus.gnt !== NB'(1 << (i % 3)) || mem_addr !== AW'(i % 3 + 1)) begin
        bad++; $display("FAIL rr_read%0d: got gnt=%b addr=%0d want %b %0d", i, bus.gnt, mem_addr, NB'(1 << (i % 3)), i % 3 + 1);
      end
      @(negedge clk);
      checks++; if (bus.r_valid !== NB'(1 << (i % 3)) || bus.r_rdata[i % 3] !== exp_d[i % 3]) begin
        bad++; $display("FAIL rr_resp%0d: got v=%b d=%h want %b %h", i, bus.r_valid, bus.r_rdata[i % 3], NB'(1 << (i % 3)), exp_d[i % 3]);
      end
    end
    for (int k = 0; k < 3; k++) drive(k, 1'b0, '0, 1'b1, 4'hF, '0);
  endtask

  task automatic test_clear_req();
    drive(0, 1'b1, BASE + 32'h4, 1'b1, 4'hF, '0);
    drive(2, 1'b1, BASE + 32'hC, 1'b1, 4'hF, '0);
    clear_req = 1'b1;
    #1;
    checks++; if (bus.gnt !== 3'b001 || mem_addr !== 4'd1 || clear_busy !== 1'b0) begin
      bad++; $display("FAIL cr_grant: got gnt=%b addr=%0d busy=%b want 001 1 0", bus.gnt, mem_addr, clear_busy);
    end
    @(negedge clk);
    clear_req = 1'b0;
    drive(0, 1'b0, '0, 1'b1, 4'hF, '0);
    checks++; if (bus.r_valid !== 3'b001 || bus.r_rdata[0] !== 32'h1111_1111) begin
      bad++; $display("FAIL cr_resp: got v=%b d=%h want 001 11111111", bus.r_valid, bus.r_rdata[0]);
    end
    #1;
    checks++; if (clear_busy !== 1'b1 || bus.gnt !== 3'b000 || mem_addr !== 4'd0 || mem_wen !== 1'b0 || mem_csn !== 1'b0) begin
      bad++; $display("FAIL cr_first: got busy=%b gnt=%b addr=%0d wen=%b csn=%b want 1 000 0 0 0",
                      clear_busy, bus.gnt, mem_addr, mem_wen, mem_csn);
    end
    @(negedge clk);
    for (int c = 1; c < 16; c++) begin
      #1;
      checks++; if (bus.gnt !== 3'b000 || mem_addr !== AW'(c) || clear_busy !== 1'b1 || bus.r_valid !== 3'b000) begin
        bad++; $display("FAIL cr_hold%0d: got gnt=%b addr=%0d busy=%b v=%b want 000 %0d 1 000", c, bus.gnt, mem_addr, clear_busy, bus.r_valid, c);
      end
      @(negedge clk);
    end
    #1;
    checks++; if (bus.gnt !== 3'b100 || clear_busy !== 1'b0 || mem_addr !== 4'd3) begin
      bad++; $display("FAIL cr_after: got gnt=%b busy=%b addr=%0d want 100 0 3", bus.gnt, clear_busy, mem_addr);
    end
    @(negedge clk);
    drive(2, 1'b0, '0, 1'b1, 4'hF, '0);
    checks++; if (bus.r_valid !== 3'b100 || bus.r_rdata[2] !== 32'h0) begin
      bad++; $display("FAIL cr_after_resp: got v=%b d=%h want 100 00000000", bus.r_valid, bus.r_rdata[2]);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) drive(k, 1'b0, '0, 1'b1, 4'hF, '0);
    test_reset();
    test_partial_write();
    test_alias();
    test_reset_mid_clear();
    test_round_robin();
    test_clear_req();
    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

endmodule
